// File: rtl/baccarat_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : baccarat_round_ctrl
// Purpose  : Round sequencer for the baccarat datapath. It issues the card
//            load strobes, applies the player/banker third-card rules and
//            declares the winner. It also handles start and auto-replay, and
//            keeps wrapping win/tie tallies.
// Ports    : slow_clock, resetb (async, active low)
//            start, auto_mode            - round control
//            pscore, dscore, pcard3      - hand scores / player third card
//            load_pcard, load_dcard      - one-hot card load strobes
//            player_win_light,
//            dealer_win_light            - result lights (both = tie)
//            busy                        - round in progress
//            round_count, player_wins,
//            dealer_wins, ties           - wrapping tallies
// Revision : 1.0 - initial release
// ============================================================================
module baccarat_round_ctrl #(
  parameter int SCORE_W     = 4,
  parameter int CNT_W       = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic               slow_clock,
  input  logic               resetb,
  input  logic               start,
  input  logic               auto_mode,
  input  logic [SCORE_W-1:0] pscore,
  input  logic [SCORE_W-1:0] dscore,
  input  logic [SCORE_W-1:0] pcard3,
  output logic [2:0]         load_pcard,
  output logic [2:0]         load_dcard,
  output logic               player_win_light,
  output logic               dealer_win_light,
  output logic               busy,
  output logic [CNT_W-1:0]   round_count,
  output logic [CNT_W-1:0]   player_wins,
  output logic [CNT_W-1:0]   dealer_wins,
  output logic [CNT_W-1:0]   ties
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_P1     = 4'd1,
    S_D1     = 4'd2,
    S_P2     = 4'd3,
    S_D2     = 4'd4,
    S_EVAL   = 4'd5,
    S_P3     = 4'd6,
    S_DCHK   = 4'd7,
    S_D3     = 4'd8,
    S_RESULT = 4'd9
  } state_t;

  // Scores above 9 are treated as 9.
  function automatic logic [3:0] clamp9(input logic [SCORE_W-1:0] v);
    if (v > SCORE_W'(9)) return 4'd9;
    return 4'(v);
  endfunction

  logic [3:0] ps, ds, c3;
  assign ps = clamp9(pscore);
  assign ds = clamp9(dscore);
  assign c3 = clamp9(pcard3);

  // Banker draw table once the player has taken a third card.
  logic dealer_draw;
  always_comb begin
    dealer_draw = 1'b0;
    case (ds)
      4'd0, 4'd1, 4'd2: dealer_draw = 1'b1;
      4'd3:             dealer_draw = (c3 != 4'd8);
      4'd4:             dealer_draw = (c3 >= 4'd2) && (c3 <= 4'd7);
      4'd5:             dealer_draw = (c3 >= 4'd4) && (c3 <= 4'd7);
      4'd6:             dealer_draw = (c3 >= 4'd6) && (c3 <= 4'd7);
      default:          dealer_draw = 1'b0;
    endcase
  end

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [2:0]        load_pcard_q, load_pcard_d;
  logic [2:0]        load_dcard_q, load_dcard_d;
  logic              pwin_q, pwin_d, dwin_q, dwin_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  round_q, round_d, pw_q, pw_d, dw_q, dw_d, tie_q, tie_d;
  logic              enter_result;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_P1;
      S_P1:     state_d = S_D1;
      S_D1:     state_d = S_P2;
      S_P2:     state_d = S_D2;
      S_D2:     state_d = S_EVAL;
      S_EVAL: begin
        if ((ps >= 4'd8) || (ds >= 4'd8)) state_d = S_RESULT;
        else if (ps <= 4'd5)              state_d = S_P3;
        else if (ds <= 4'd5)              state_d = S_D3;
        else                              state_d = S_RESULT;
      end
      S_P3:     state_d = S_DCHK;
      S_DCHK:   state_d = dealer_draw ? S_D3 : S_RESULT;
      S_D3:     state_d = S_RESULT;
      S_RESULT: begin
        if (start)                                 state_d = S_P1;
        else if (auto_mode && (hold_q == HOLD_LAST)) state_d = S_P1;
        else                                       state_d = S_RESULT;
      end
      default:  state_d = S_IDLE;
    endcase

    enter_result = (state_d == S_RESULT) && (state_q != S_RESULT);

    // Dwell timer: zero on entry, saturating count while RESULT is held.
    hold_d = '0;
    if ((state_q == S_RESULT) && (state_d == S_RESULT))
      hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1;

    // Outputs are registered, decoded from the state being entered.
    load_pcard_d = {state_d == S_P3, state_d == S_P2, state_d == S_P1};
    load_dcard_d = {state_d == S_D3, state_d == S_D2, state_d == S_D1};
    busy_d       = (state_d != S_IDLE) && (state_d != S_RESULT);

    // Lights are captured on the entry edge and held through RESULT.
    pwin_d = 1'b0;
    dwin_d = 1'b0;
    if (enter_result) begin
      pwin_d = (ps >= ds);
      dwin_d = (ds >= ps);
    end else if (state_d == S_RESULT) begin
      pwin_d = pwin_q;
      dwin_d = dwin_q;
    end

    round_d = round_q;
    pw_d    = pw_q;
    dw_d    = dw_q;
    tie_d   = tie_q;
    if (enter_result) begin
      round_d = round_q + 1'b1;
      if (ps > ds)      pw_d  = pw_q + 1'b1;
      else if (ds > ps) dw_d  = dw_q + 1'b1;
      else              tie_d = tie_q + 1'b1;
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      load_pcard_q <= 3'b000;
      load_dcard_q <= 3'b000;
      pwin_q       <= 1'b0;
      dwin_q       <= 1'b0;
      busy_q       <= 1'b0;
      round_q      <= '0;
      pw_q         <= '0;
      dw_q         <= '0;
      tie_q        <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      load_pcard_q <= load_pcard_d;
      load_dcard_q <= load_dcard_d;
      pwin_q       <= pwin_d;
      dwin_q       <= dwin_d;
      busy_q       <= busy_d;
      round_q      <= round_d;
      pw_q         <= pw_d;
      dw_q         <= dw_d;
      tie_q        <= tie_d;
    end
  end

  assign load_pcard       = load_pcard_q;
  assign load_dcard       = load_dcard_q;
  assign player_win_light = pwin_q;
  assign dealer_win_light = dwin_q;
  assign busy             = busy_q;
  assign round_count      = round_q;
  assign player_wins      = pw_q;
  assign dealer_wins      = dw_q;
  assign ties             = tie_q;

endmodule
`default_nettype wire

// File: tb/tb_baccarat_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_baccarat_round_ctrl
// Purpose  : Self-checking bench for baccarat_round_ctrl. Two instances share
//            stimulus: one with 8-bit tallies, one with 2-bit tallies so that
//            counter wrap is exercised. Rounds follow the card-game rules in a
//            behavioural model that predicts strobe order, lights and tallies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_baccarat_round_ctrl;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       start = 1'b0;
  logic       auto_mode = 1'b0;
  logic [3:0] pscore = 4'd0, dscore = 4'd0, pcard3 = 4'd0;

  logic [2:0] load_pcard_a, load_dcard_a, load_pcard_b, load_dcard_b;
  logic       pl_a, dl_a, busy_a, pl_b, dl_b, busy_b;
  logic [7:0] rc_a, pw_a, dw_a, ti_a;
  logic [1:0] rc_b, pw_b, dw_b, ti_b;

  baccarat_round_ctrl #(.SCORE_W(4), .CNT_W(8), .HOLD_CYCLES(HOLD)) u_dut_a (
    .slow_clock(clk), .resetb(resetb), .start(start), .auto_mode(auto_mode),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard(load_pcard_a), .load_dcard(load_dcard_a),
    .player_win_light(pl_a), .dealer_win_light(dl_a), .busy(busy_a),
    .round_count(rc_a), .player_wins(pw_a), .dealer_wins(dw_a), .ties(ti_a)
  );

  baccarat_round_ctrl #(.SCORE_W(4), .CNT_W(2), .HOLD_CYCLES(HOLD)) u_dut_b (
    .slow_clock(clk), .resetb(resetb), .start(start), .auto_mode(auto_mode),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard(load_pcard_b), .load_dcard(load_dcard_b),
    .player_win_light(pl_b), .dealer_win_light(dl_b), .busy(busy_b),
    .round_count(rc_b), .player_wins(pw_b), .dealer_wins(dw_b), .ties(ti_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_rounds = 0, m_pw = 0, m_dw = 0, m_ties = 0;
  bit last_pl = 1'b0, last_dl = 1'b0;
  bit in_result = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cl(input int v);
    return (v > 9) ? 9 : v;
  endfunction

  // Banker third-card rule given banker total and player's third card.
  function automatic bit banker_draws(input int d, input int c);
    if (d <= 2) return 1'b1;
    if (d == 3) return c != 8;
    if (d == 4) return c >= 2 && c <= 7;
    if (d == 5) return c >= 4 && c <= 7;
    if (d == 6) return c >= 6 && c <= 7;
    return 1'b0;
  endfunction

  // Advance one clock, then compare the control outputs.
  task automatic step(input string tag, input int pc, input int dc, input bit bz,
                      input bit pl, input bit dl, input bit noise);
    @(posedge clk);
    #1;
    chk({tag, ".load_pcard"}, 32'(load_pcard_a), 32'(pc));
    chk({tag, ".load_dcard"}, 32'(load_dcard_a), 32'(dc));
    chk({tag, ".busy"}, 32'(busy_a), 32'(bz));
    chk({tag, ".busy_b"}, 32'(busy_b), 32'(bz));
    chk({tag, ".player_light"}, 32'(pl_a), 32'(pl));
    chk({tag, ".dealer_light"}, 32'(dl_a), 32'(dl));
    // Random start pulses while busy must be ignored.
    start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic check_tallies(input string tag);
    chk({tag, ".round_count"}, 32'(rc_a), 32'(m_rounds % 256));
    chk({tag, ".player_wins"}, 32'(pw_a), 32'(m_pw % 256));
    chk({tag, ".dealer_wins"}, 32'(dw_a), 32'(m_dw % 256));
    chk({tag, ".ties"}, 32'(ti_a), 32'(m_ties % 256));
    chk({tag, ".round_count_w2"}, 32'(rc_b), 32'(m_rounds % 4));
    chk({tag, ".player_wins_w2"}, 32'(pw_b), 32'(m_pw % 4));
    chk({tag, ".dealer_wins_w2"}, 32'(dw_b), 32'(m_dw % 4));
    chk({tag, ".ties_w2"}, 32'(ti_b), 32'(m_ties % 4));
  endtask

  // One full round. pe/de: scores at evaluation; c3: player third card;
  // pf_in/df_in: scores after the player/dealer third card, if drawn.
  task automatic play_round(input int pe, input int de, input int c3,
                            input int pf_in, input int df_in, input bit via_auto);
    int p, d, pf, df;
    bit pl, dl;
    if (via_auto && in_result) begin
      auto_mode = 1'b1;
      start = 1'b0;
      repeat (HOLD - 1) step("hold", 0, 0, 1'b0, last_pl, last_dl, 1'b0);
      step("auto_p1", 1, 0, 1'b1, 1'b0, 1'b0, 1'b1);
      auto_mode = 1'b0;
    end else begin
      repeat ($urandom_range(0, 2)) step("stay", 0, 0, 1'b0, last_pl, last_dl, 1'b0);
      start = 1'b1;
      step("p1", 1, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    step("d1", 0, 1, 1'b1, 1'b0, 1'b0, 1'b1);
    step("p2", 2, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("d2", 0, 2, 1'b1, 1'b0, 1'b0, 1'b1);
    pscore = 4'(pe);
    dscore = 4'(de);
    pcard3 = 4'($urandom_range(0, 15));
    step("eval", 0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    p  = cl(pe);
    d  = cl(de);
    pf = pe;
    df = de;
    if (p >= 8 || d >= 8) begin
      // natural: straight to result
    end else if (p <= 5) begin
      step("p3", 4, 0, 1'b1, 1'b0, 1'b0, 1'b1);
      pscore = 4'(pf_in);
      pcard3 = 4'(c3);
      pf = pf_in;
      step("dchk", 0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
      if (banker_draws(d, cl(c3))) begin
        step("d3", 0, 4, 1'b1, 1'b0, 1'b0, 1'b1);
        dscore = 4'(df_in);
        df = df_in;
      end
    end else if (d <= 5) begin
      step("d3", 0, 4, 1'b1, 1'b0, 1'b0, 1'b1);
      dscore = 4'(df_in);
      df = df_in;
    end
    pl = cl(pf) >= cl(df);
    dl = cl(df) >= cl(pf);
    m_rounds++;
    if (cl(pf) > cl(df))      m_pw++;
    else if (cl(df) > cl(pf)) m_dw++;
    else                      m_ties++;
    step("result", 0, 0, 1'b0, pl, dl, 1'b0);
    check_tallies("result");
    last_pl   = pl;
    last_dl   = dl;
    in_result = 1'b1;
  endtask

  task automatic reset_mid_round();
    start = 1'b1;
    step("r_p1", 1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("r_d1", 0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("r_p2", 2, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("r_d2", 0, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    resetb = 1'b0;
    #1;
    m_rounds = 0; m_pw = 0; m_dw = 0; m_ties = 0;
    chk("rst_mid.load_pcard", 32'(load_pcard_a), 32'd0);
    chk("rst_mid.load_dcard", 32'(load_dcard_a), 32'd0);
    chk("rst_mid.busy", 32'(busy_a), 32'd0);
    check_tallies("rst_mid");
    @(negedge clk);
    resetb = 1'b1;
    last_pl = 1'b0;
    last_dl = 1'b0;
    in_result = 1'b0;
    repeat (2) step("rst_idle", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("reset.load_pcard", 32'(load_pcard_a), 32'd0);
    chk("reset.load_dcard", 32'(load_dcard_a), 32'd0);
    chk("reset.busy", 32'(busy_a), 32'd0);
    chk("reset.player_light", 32'(pl_a), 32'd0);
    chk("reset.dealer_light", 32'(dl_a), 32'd0);
    check_tallies("reset");
    @(negedge clk);
    resetb = 1'b1;
    step("idle", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Directed scenarios
    play_round(9, 3, 0, 9, 3, 1'b0);      // natural player win
    play_round(4, 5, 5, 9, 2, 1'b0);      // both draw
    play_round(4, 5, 3, 7, 5, 1'b1);      // player draws, banker stands; auto replay
    play_round(6, 2, 0, 6, 6, 1'b1);      // player stands, banker draws to a tie
    play_round(7, 7, 0, 7, 7, 1'b0);      // both stand, tie
    play_round(4, 7, 6, 2, 7, 1'b1);      // banker on 7 never draws
    play_round(4, 6, 8, 1, 6, 1'b0);      // 6 vs card 8: stand
    play_round(12, 3, 0, 12, 3, 1'b0);    // out-of-range score clamps to 9
    for (int i = 0; i < 4; i++)
      play_round(0, 8, 0, 0, 8, i[0]);    // dealer naturals wrap the 2-bit tally

    reset_mid_round();

    // Randomized rounds
    for (int i = 0; i < 60; i++) begin
      int hi;
      hi = ($urandom_range(0, 7) == 0) ? 15 : 9;
      play_round($urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi),
                 $urandom_range(0, hi), $urandom_range(0, hi), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
